// File: rtl/updown_bounce_counter.sv
// updown_bounce_counter: bounded up/down counter with bounce, wrap and saturate bound modes.
module updown_bounce_counter #(
  parameter int WIDTH = 3,
  parameter bit RST_DIR_UP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reverse,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] counter,
  output logic             dir_up,
  output logic             turn,
  output logic             wrap,
  output logic             sat,
  output logic             cfg_err
);
  logic [WIDTH-1:0] cnt_n;
  logic dir_n, turn_n, wrap_n, sat_n, d, m_wrap, m_sat;
  assign cfg_err = lo >= hi;
  assign d = dir_up ^ reverse;
  assign m_wrap = mode == 2'b01;
  assign m_sat = mode == 2'b10;
  always_comb begin
    cnt_n = counter;
    dir_n = dir_up;
    turn_n = 1'b0;
    wrap_n = 1'b0;
    sat_n = 1'b0;
    if (clear) cnt_n = lo;
    else if (load) cnt_n = load_val;
    else if (en) begin
      dir_n = d;
      if (cfg_err) cnt_n = lo;
      else if (counter > hi) cnt_n = hi;
      else if (counter < lo) cnt_n = lo;
      else if (d && counter == hi) begin
        cnt_n = m_wrap ? lo : m_sat ? counter : hi - WIDTH'(1);
        dir_n = m_wrap || m_sat;
        wrap_n = m_wrap;
        sat_n = m_sat;
        turn_n = !m_wrap && !m_sat;
      end else if (!d && counter == lo) begin
        cnt_n = m_wrap ? hi : m_sat ? counter : lo + WIDTH'(1);
        dir_n = !(m_wrap || m_sat);
        wrap_n = m_wrap;
        sat_n = m_sat;
        turn_n = !m_wrap && !m_sat;
      end else cnt_n = d ? counter + WIDTH'(1) : counter - WIDTH'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      counter <= '0;
      dir_up <= RST_DIR_UP;
      turn <= 1'b0;
      wrap <= 1'b0;
      sat <= 1'b0;
    end else begin
      counter <= cnt_n;
      dir_up <= dir_n;
      turn <= turn_n;
      wrap <= wrap_n;
      sat <= sat_n;
    end
endmodule

// File: tb/tb_updown_bounce_counter.sv
// tb_updown_bounce_counter: directed scoreboard bench for updown_bounce_counter (WIDTH=3).
module tb_updown_bounce_counter;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clear = 1'b0, load = 1'b0, reverse = 1'b0;
  logic [2:0] load_val = '0, lo = 3'd0, hi = 3'd6, counter;
  logic [1:0] mode = 2'b00;
  logic dir_up, turn, wrap, sat, cfg_err;
  logic [6:0] exp_q[$];
  string tag_q[$];
  int tests = 0, fails = 0;

  updown_bounce_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .load(load), .load_val(load_val),
    .reverse(reverse), .mode(mode), .lo(lo), .hi(hi), .counter(counter), .dir_up(dir_up),
    .turn(turn), .wrap(wrap), .sat(sat), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ex(input logic [2:0] c, input logic d, t, w, s);
    return {c, d, t, w, s};
  endfunction

  task automatic compare();
    logic [6:0] obs, e;
    string t;
    obs = {counter, dir_up, turn, wrap, sat};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed {cnt,dir,turn,wrap,sat}=%b required=%b", t, obs, e);
    end
  endtask

  task automatic now(input string tag, input logic [6:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare();
  endtask

  task automatic cyc(input string tag, input logic [6:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic chk_cfg(input string tag, input logic e);
    tests++;
    assert (cfg_err === e) else begin
      fails++;
      $error("FAIL %s observed cfg_err=%b required=%b", tag, cfg_err, e);
    end
  endtask

  initial begin
    logic [2:0] seq [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    #12;
    now("reset", ex(0, 1, 0, 0, 0));
    chk_cfg("cfg_ok", 1'b0);
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 14; i++)
      cyc($sformatf("bounce%0d", i), ex(seq[i], (i <= 5) || (i >= 12), (i == 6) || (i == 12), 0, 0));
    en = 1'b0;
    reverse = 1'b1;
    cyc("hold_rev_ignored", ex(2, 1, 0, 0, 0));
    reverse = 1'b0;
    load = 1'b1;
    load_val = 3'd5;
    cyc("load5", ex(5, 1, 0, 0, 0));
    load = 1'b0;
    en = 1'b1;
    mode = 2'b01;
    cyc("wrap_6", ex(6, 1, 0, 0, 0));
    cyc("wrap_0", ex(0, 1, 0, 1, 0));
    cyc("wrap_1", ex(1, 1, 0, 0, 0));
    reverse = 1'b1;
    cyc("wrap_rev_0", ex(0, 0, 0, 0, 0));
    reverse = 1'b0;
    cyc("wrap_dn_6", ex(6, 0, 0, 1, 0));
    mode = 2'b10;
    reverse = 1'b1;
    cyc("sat_a", ex(6, 1, 0, 0, 1));
    reverse = 1'b0;
    cyc("sat_b", ex(6, 1, 0, 0, 1));
    cyc("sat_c", ex(6, 1, 0, 0, 1));
    reverse = 1'b1;
    cyc("sat_rev", ex(5, 0, 0, 0, 0));
    clear = 1'b1;
    load = 1'b1;
    load_val = 3'd3;
    cyc("clr_prio", ex(0, 0, 0, 0, 0));
    clear = 1'b0;
    cyc("load_rev", ex(3, 0, 0, 0, 0));
    reverse = 1'b0;
    load_val = 3'd6;
    cyc("load6", ex(6, 0, 0, 0, 0));
    load = 1'b0;
    mode = 2'b00;
    hi = 3'd4;
    cyc("above_hi", ex(4, 0, 0, 0, 0));
    lo = 3'd5;
    hi = 3'd5;
    #1;
    chk_cfg("cfg_err_eq", 1'b1);
    cyc("cfg_err_lo", ex(5, 0, 0, 0, 0));
    lo = 3'd3;
    hi = 3'd6;
    load = 1'b1;
    load_val = 3'd1;
    cyc("load1", ex(1, 0, 0, 0, 0));
    load = 1'b0;
    reverse = 1'b1;
    cyc("below_lo", ex(3, 1, 0, 0, 0));
    reverse = 1'b0;
    lo = 3'd0;
    mode = 2'b11;
    load = 1'b1;
    load_val = 3'd6;
    cyc("load6b", ex(6, 1, 0, 0, 0));
    load = 1'b0;
    cyc("rsvd_bounce", ex(5, 0, 1, 0, 0));
    mode = 2'b00;
    load = 1'b1;
    load_val = 3'd4;
    cyc("load4", ex(4, 0, 0, 0, 0));
    load = 1'b0;
    en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    now("async_rst", ex(0, 1, 0, 0, 0));
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    cyc("post_rst", ex(1, 1, 0, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
